// File: rtl/scene_pkg.sv
// Shared types and screen defaults for the scene sequencer.
package scene_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    CLEAR  = 3'd1,
    SEEK   = 3'd2,
    LAUNCH = 3'd3,
    REARM  = 3'd4,
    FINISH = 3'd5
  } state_t;

  typedef struct packed {
    logic       valid;
    logic [2:0] colour;
    logic [7:0] cx;
    logic [6:0] cy;
    logic [7:0] r;
  } circle_entry_t;

  localparam int         DEF_SCREEN_W  = 160;
  localparam int         DEF_SCREEN_H  = 120;
  localparam logic [2:0] DEF_BG_COLOUR = 3'b000;

endpackage

// File: rtl/scene_ctrl_clear_engine.sv
// Raster counter for the clear pass: one plot per cycle over the whole screen.
module clear_engine
  import scene_pkg::*;
#(
  parameter int W = DEF_SCREEN_W,
  parameter int H = DEF_SCREEN_H
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic       start,
  output logic       plot,
  output logic [7:0] x,
  output logic [6:0] y,
  output logic       last
);

  // x/y advance while plotting; plot drops after the bottom-right pixel
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      plot <= 1'b0;
      x    <= 8'd0;
      y    <= 7'd0;
    end else if (start && !plot) begin
      plot <= 1'b1;
      x    <= 8'd0;
      y    <= 7'd0;
    end else if (plot) begin
      if (x == 8'(W - 1)) begin
        x <= 8'd0;
        if (y == 7'(H - 1)) begin
          plot <= 1'b0;
          y    <= 7'd0;
        end else begin
          y <= y + 7'd1;
        end
      end else begin
        x <= x + 8'd1;
      end
    end
  end

  assign last = plot && (x == 8'(W - 1)) && (y == 7'(H - 1));

endmodule

// File: rtl/scene_ctrl.sv
// Scene sequencer: clears the framebuffer, then launches the circle engine
// once per valid table entry while sharing the single VGA plot port.
module scene_ctrl
  import scene_pkg::*;
#(
  parameter int         NUM_CIRCLES = 4,
  parameter int         SCREEN_W    = DEF_SCREEN_W,
  parameter int         SCREEN_H    = DEF_SCREEN_H,
  parameter logic [2:0] BG_COLOUR   = DEF_BG_COLOUR
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic       start,
  output logic       done,
  input  logic       cfg_we,
  input  logic [3:0] cfg_idx,
  input  logic       cfg_valid,
  input  logic [2:0] cfg_colour,
  input  logic [7:0] cfg_cx,
  input  logic [6:0] cfg_cy,
  input  logic [7:0] cfg_r,
  output logic       circ_start,
  input  logic       circ_done,
  output logic [2:0] circ_colour,
  output logic [7:0] circ_centre_x,
  output logic [6:0] circ_centre_y,
  output logic [7:0] circ_radius,
  input  logic [7:0] circ_vga_x,
  input  logic [6:0] circ_vga_y,
  input  logic [2:0] circ_vga_colour,
  input  logic       circ_vga_plot,
  output logic [7:0] vga_x,
  output logic [6:0] vga_y,
  output logic [2:0] vga_colour,
  output logic       vga_plot
);

  state_t        state_r;
  logic [4:0]    idx_r;
  circle_entry_t tbl_r [NUM_CIRCLES];
  circle_entry_t cur_r;
  circle_entry_t seek_entry_s;
  logic          ce_start_s;
  logic          ce_plot_s;
  logic          ce_last_s;
  logic [7:0]    ce_x_s;
  logic [6:0]    ce_y_s;

  assign ce_start_s = (state_r == IDLE) && start;

  clear_engine #(.W(SCREEN_W), .H(SCREEN_H)) u_clear (
    .clk   (clk),
    .rstn  (rstn),
    .start (ce_start_s),
    .plot  (ce_plot_s),
    .x     (ce_x_s),
    .y     (ce_y_s),
    .last  (ce_last_s)
  );

  // Table is only writable while idle so a running scene sees a frozen copy
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < NUM_CIRCLES; i++) tbl_r[i] <= '0;
    end else if ((state_r == IDLE) && cfg_we && ({1'b0, cfg_idx} < 5'(NUM_CIRCLES))) begin
      for (int i = 0; i < NUM_CIRCLES; i++) begin
        if (cfg_idx == 4'(i)) tbl_r[i] <= '{cfg_valid, cfg_colour, cfg_cx, cfg_cy, cfg_r};
      end
    end
  end

  always_comb begin
    seek_entry_s = '0;
    for (int i = 0; i < NUM_CIRCLES; i++) begin
      seek_entry_s = (idx_r == 5'(i)) ? tbl_r[i] : seek_entry_s;
    end
  end

  // Sequencer FSM with registered done/circ_start and latched entry fields
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_r    <= IDLE;
      idx_r      <= 5'd0;
      done       <= 1'b0;
      circ_start <= 1'b0;
      cur_r      <= '0;
    end else begin
      case (state_r)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            state_r <= CLEAR;
            idx_r   <= 5'd0;
          end
        end
        CLEAR: begin
          if (ce_last_s) state_r <= SEEK;
        end
        SEEK: begin
          if (idx_r == 5'(NUM_CIRCLES)) begin
            state_r <= FINISH;
            done    <= 1'b1;
          end else if (seek_entry_s.valid) begin
            state_r    <= LAUNCH;
            circ_start <= 1'b1;
            cur_r      <= seek_entry_s;
          end else begin
            idx_r <= idx_r + 5'd1;
          end
        end
        LAUNCH: begin
          if (circ_done) begin
            state_r    <= REARM;
            circ_start <= 1'b0;
          end
        end
        // Engine must see start low before the next launch
        REARM: begin
          if (!circ_done) begin
            state_r <= SEEK;
            idx_r   <= idx_r + 5'd1;
          end
        end
        FINISH: begin
          if (!start) begin
            state_r <= IDLE;
            done    <= 1'b0;
          end
        end
        default: begin
          state_r    <= IDLE;
          done       <= 1'b0;
          circ_start <= 1'b0;
        end
      endcase
    end
  end

  assign circ_colour   = cur_r.colour;
  assign circ_centre_x = cur_r.cx;
  assign circ_centre_y = cur_r.cy;
  assign circ_radius   = cur_r.r;

  // Plot port owner: clear engine in CLEAR, circle engine in LAUNCH/REARM
  always_comb begin
    vga_x      = 8'd0;
    vga_y      = 7'd0;
    vga_colour = 3'd0;
    vga_plot   = 1'b0;
    case (state_r)
      CLEAR: begin
        vga_x      = ce_x_s;
        vga_y      = ce_y_s;
        vga_colour = BG_COLOUR;
        vga_plot   = ce_plot_s;
      end
      LAUNCH, REARM: begin
        vga_x      = circ_vga_x;
        vga_y      = circ_vga_y;
        vga_colour = circ_vga_colour;
        vga_plot   = circ_vga_plot;
      end
      default: begin
        vga_plot = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_scene_ctrl.sv
// Directed bench for scene_ctrl with a behavioural circle engine (done latency 50).
module tb_scene_ctrl;

  localparam int N = 4;

  logic       clk = 1'b0;
  logic       rstn = 1'b0;
  logic       start = 1'b0;
  logic       done;
  logic       cfg_we = 1'b0;
  logic [3:0] cfg_idx = 4'd0;
  logic       cfg_valid = 1'b0;
  logic [2:0] cfg_colour = 3'd0;
  logic [7:0] cfg_cx = 8'd0;
  logic [6:0] cfg_cy = 7'd0;
  logic [7:0] cfg_r = 8'd0;
  logic       circ_start;
  logic       circ_done;
  logic [2:0] circ_colour;
  logic [7:0] circ_centre_x;
  logic [6:0] circ_centre_y;
  logic [7:0] circ_radius;
  logic [7:0] circ_vga_x;
  logic [6:0] circ_vga_y;
  logic [2:0] circ_vga_colour;
  logic       circ_vga_plot;
  logic [7:0] vga_x;
  logic [6:0] vga_y;
  logic [2:0] vga_colour;
  logic       vga_plot;

  always #5 clk = ~clk;

  scene_ctrl #(.NUM_CIRCLES(N)) dut (
    .clk(clk), .rstn(rstn), .start(start), .done(done),
    .cfg_we(cfg_we), .cfg_idx(cfg_idx), .cfg_valid(cfg_valid), .cfg_colour(cfg_colour),
    .cfg_cx(cfg_cx), .cfg_cy(cfg_cy), .cfg_r(cfg_r),
    .circ_start(circ_start), .circ_done(circ_done), .circ_colour(circ_colour),
    .circ_centre_x(circ_centre_x), .circ_centre_y(circ_centre_y), .circ_radius(circ_radius),
    .circ_vga_x(circ_vga_x), .circ_vga_y(circ_vga_y), .circ_vga_colour(circ_vga_colour),
    .circ_vga_plot(circ_vga_plot),
    .vga_x(vga_x), .vga_y(vga_y), .vga_colour(vga_colour), .vga_plot(vga_plot)
  );

  // Behavioural circle engine: 50 busy cycles, done held until start drops
  int         n_launch = 0;
  int         bad_launch = 0;
  int         fld_change = 0;
  logic [2:0] l_col [16];
  logic [7:0] l_cx  [16];
  logic [6:0] l_cy  [16];
  logic [7:0] l_r   [16];
  logic [25:0] m_fields;
  logic       m_busy, prev_cs;
  int         m_cnt;

  always @(posedge clk) begin
    if (!rstn) begin
      m_busy <= 1'b0; m_cnt <= 0; prev_cs <= 1'b0; circ_done <= 1'b0;
      circ_vga_x <= 8'd0; circ_vga_y <= 7'd0; circ_vga_colour <= 3'd0; circ_vga_plot <= 1'b0;
    end else begin
      prev_cs <= circ_start;
      if (circ_start && !prev_cs) begin
        if (circ_done || m_busy) bad_launch <= bad_launch + 1;
        if (n_launch < 16) begin
          l_col[n_launch[3:0]] <= circ_colour;
          l_cx[n_launch[3:0]]  <= circ_centre_x;
          l_cy[n_launch[3:0]]  <= circ_centre_y;
          l_r[n_launch[3:0]]   <= circ_radius;
        end
        n_launch <= n_launch + 1;
        m_fields <= {circ_colour, circ_centre_x, circ_centre_y, circ_radius};
        m_busy   <= 1'b1;
        m_cnt    <= 0;
      end else if (m_busy) begin
        m_cnt           <= m_cnt + 1;
        circ_vga_x      <= circ_centre_x + 8'(m_cnt);
        circ_vga_y      <= circ_centre_y - 7'(m_cnt);
        circ_vga_colour <= circ_colour;
        circ_vga_plot   <= m_cnt[0];
        if (m_cnt == 49) begin
          m_busy        <= 1'b0;
          circ_done     <= 1'b1;
          circ_vga_plot <= 1'b0;
        end
      end else if (circ_done && !circ_start) begin
        circ_done <= 1'b0;
      end
      if (circ_start && prev_cs &&
          ({circ_colour, circ_centre_x, circ_centre_y, circ_radius} !== m_fields))
        fld_change <= fld_change + 1;
    end
  end

  int tests = 0;
  int fails = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic cfg_write(input logic [3:0] idx, input logic v, input logic [2:0] c,
                           input logic [7:0] x, input logic [6:0] y, input logic [7:0] r);
    cfg_we = 1'b1; cfg_idx = idx; cfg_valid = v; cfg_colour = c; cfg_cx = x; cfg_cy = y; cfg_r = r;
    tick();
    cfg_we = 1'b0;
  endtask

  int          sc_plots, sc_badcol, sc_passmis, sc_circ_plots, sc_last_cyc, sc_done_cyc;
  logic        sc_cs_seen;
  logic [14:0] p1, p160, p161, plast;

  // Runs until done rises; classifies clear plots vs circle passthrough
  task automatic run_scene(input int budget, input bit inject);
    sc_plots = 0; sc_badcol = 0; sc_passmis = 0; sc_circ_plots = 0;
    sc_last_cyc = 0; sc_done_cyc = -1; sc_cs_seen = 1'b0;
    p1 = '1; p160 = '1; p161 = '1; plast = '1;
    for (int c = 0; c < budget; c++) begin
      tick();
      if (inject && c == 5) begin
        cfg_we = 1'b1; cfg_idx = 4'd1; cfg_valid = 1'b1; cfg_colour = 3'd7;
        cfg_cx = 8'd1; cfg_cy = 7'd1; cfg_r = 8'd1;
      end else begin
        cfg_we = 1'b0;
      end
      if (done) begin
        sc_done_cyc = c;
        break;
      end
      if (circ_start) begin
        sc_cs_seen = 1'b1;
        if (vga_plot) sc_circ_plots++;
        if ({vga_x, vga_y, vga_colour, vga_plot} !== {circ_vga_x, circ_vga_y, circ_vga_colour, circ_vga_plot})
          sc_passmis++;
      end else if (vga_plot) begin
        sc_plots++;
        if (vga_colour !== 3'd0) sc_badcol++;
        if (sc_plots == 1)   p1   = {vga_x, vga_y};
        if (sc_plots == 160) p160 = {vga_x, vga_y};
        if (sc_plots == 161) p161 = {vga_x, vga_y};
        plast = {vga_x, vga_y};
        sc_last_cyc = c;
      end
    end
    cfg_we = 1'b0;
  endtask

  int base, bad;
  logic [14:0] e160, e161, elast;

  initial begin
    e160 = {8'd159, 7'd0};
    e161 = {8'd0, 7'd1};
    elast = {8'd159, 7'd119};

    // Reset and idle
    repeat (3) tick();
    chk("reset_outputs", {done, circ_start, vga_plot, vga_x, vga_y, vga_colour}, 32'd0);
    rstn = 1'b1;
    bad = 0;
    for (int i = 0; i < 100; i++) begin
      tick();
      if ({done, circ_start, vga_plot, vga_x, vga_y, vga_colour} !== 21'd0) bad++;
    end
    chk("idle_quiet", bad, 32'd0);

    // Empty table: clear pass only
    start = 1'b1;
    run_scene(20000, 1'b0);
    chk("empty_done", (sc_done_cyc >= 0), 32'd1);
    chk("empty_plots", sc_plots, 32'd19200);
    chk("empty_first", p1, 32'd0);
    chk("empty_160th", p160, e160);
    chk("empty_161st", p161, e161);
    chk("empty_last", plast, elast);
    chk("empty_colour", sc_badcol, 32'd0);
    chk("empty_no_launch", sc_cs_seen, 32'd0);
    chk("empty_done_lat", ((sc_done_cyc - sc_last_cyc) <= N + 2), 32'd1);

    // Start held past done
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (done !== 1'b1 || vga_plot !== 1'b0) bad++;
    end
    chk("done_held", bad, 32'd0);
    start = 1'b0;
    chk("done_before_drop", done, 32'd1);
    tick();
    chk("done_after_drop", done, 32'd0);

    // Load entries 0 and 2; out-of-range index 5 must be ignored
    cfg_write(4'd0, 1'b1, 3'd2, 8'd80, 7'd60, 8'd40);
    cfg_write(4'd2, 1'b1, 3'd4, 8'd20, 7'd20, 8'd10);
    cfg_write(4'd5, 1'b1, 3'd7, 8'd99, 7'd99, 8'd99);
    tick();

    // Circle scene, with a table write attempted during CLEAR
    base = n_launch;
    start = 1'b1;
    run_scene(20000, 1'b1);
    chk("circ_done_seen", (sc_done_cyc >= 0), 32'd1);
    chk("circ_clear_plots", sc_plots, 32'd19200);
    chk("restart_first", p1, 32'd0);
    chk("circ_launches", n_launch - base, 32'd2);
    chk("l0_colour", l_col[base[3:0]], 32'd2);
    chk("l0_cx", l_cx[base[3:0]], 32'd80);
    chk("l0_cy", l_cy[base[3:0]], 32'd60);
    chk("l0_r", l_r[base[3:0]], 32'd40);
    chk("l1_colour", l_col[base[3:0] + 4'd1], 32'd4);
    chk("l1_cx", l_cx[base[3:0] + 4'd1], 32'd20);
    chk("l1_cy", l_cy[base[3:0] + 4'd1], 32'd20);
    chk("l1_r", l_r[base[3:0] + 4'd1], 32'd10);
    chk("launch_rearm", bad_launch, 32'd0);
    chk("fields_stable", fld_change, 32'd0);
    chk("passthrough", sc_passmis, 32'd0);
    chk("circ_plots_seen", (sc_circ_plots > 0), 32'd1);
    start = 1'b0;
    tick();
    chk("done_clear2", done, 32'd0);

    // Reset during second launch
    base = n_launch;
    start = 1'b1;
    for (int i = 0; i < 21000; i++) begin
      tick();
      if (n_launch == base + 2) break;
    end
    repeat (10) tick();
    chk("mid_launch", circ_start, 32'd1);
    rstn = 1'b0;
    #1;
    chk("async_reset_outs", {done, circ_start, vga_plot, vga_x, vga_y, vga_colour}, 32'd0);
    start = 1'b0;
    bad = 0;
    for (int i = 0; i < 3; i++) begin
      tick();
      if ({done, circ_start, vga_plot} !== 3'd0) bad++;
    end
    chk("reset_hold_quiet", bad, 32'd0);
    rstn = 1'b1;
    tick();
    base = n_launch;
    start = 1'b1;
    run_scene(20000, 1'b0);
    chk("post_reset_done", (sc_done_cyc >= 0), 32'd1);
    chk("post_reset_plots", sc_plots, 32'd19200);
    chk("post_reset_no_launch", n_launch - base, 32'd0);
    start = 1'b0;
    tick();
    chk("post_reset_idle", done, 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
